fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited imem requests, in-order PC tag FIFO and instruction buffer to decode.
// Optional macro FETCH_MISALIGN_CHECK_EN adds a sticky misalign_fault output.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IBUF_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        system_stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic [31:0] instruction,
   output logic [31:0] pc_out,
   output logic        uop_valid_out
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic        misalign_fault
`endif
);
   localparam int          PW      = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
   localparam int          CW      = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(IBUF_DEPTH);

   logic [31:0]   pc_reg;
   logic [CW-1:0] occ_reg;
   logic [CW-1:0] out_reg;
   logic [CW-1:0] drop_reg;
   logic [PW-1:0] buf_wr_ptr_reg;
   logic [PW-1:0] buf_rd_ptr_reg;
   logic [PW-1:0] tag_wr_ptr_reg;
   logic [PW-1:0] tag_rd_ptr_reg;
   logic [31:0]   buf_instr_reg [IBUF_DEPTH];
   logic [31:0]   buf_pc_reg    [IBUF_DEPTH];
   logic [31:0]   tag_pc_reg    [IBUF_DEPTH];

   logic [31:0]   redirect_target;
   logic          suppress;
   logic [CW:0]   credit_sum;
   logic          credit_ok;
   logic          accept;
   logic          drop_resp;
   logic          push;
   logic          pop;
   logic [CW-1:0] resp_dec;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic suppress_reg;
   logic misalign_reg;

   assign redirect_target = redirect_pc;
   assign suppress        = suppress_reg;
   assign misalign_fault  = misalign_reg;

   // The fault flag is sticky until reset; only request suppression clears on an aligned redirect.
   always_ff @(posedge clk) begin
      if (reset) begin
         suppress_reg <= 1'b0;
         misalign_reg <= 1'b0;
      end else if (redirect_valid) begin
         suppress_reg <= (redirect_pc[1:0] != 2'b00);
         if (redirect_pc[1:0] != 2'b00) begin
            misalign_reg <= 1'b1;
         end
      end
   end
`else
   logic unused_pc_bits;

   assign unused_pc_bits  = ^redirect_pc[1:0];
   assign redirect_target = {redirect_pc[31:2], 2'b00};
   assign suppress        = 1'b0;
`endif

   // Outstanding includes responses still to be dropped, so the buffer can never overflow.
   assign credit_sum     = {1'b0, occ_reg} + {1'b0, out_reg};
   assign credit_ok      = credit_sum < DEPTH_C;
   assign imem_req_valid = !reset && !redirect_valid && !suppress && credit_ok;
   assign imem_req_addr  = pc_reg;
   assign accept         = imem_req_valid && imem_req_ready;

   assign drop_resp      = imem_resp_valid && (drop_reg != '0);
   assign push           = imem_resp_valid && (drop_reg == '0) && !redirect_valid;
   assign uop_valid_out  = (occ_reg != '0);
   assign pop            = uop_valid_out && !system_stall && !redirect_valid;
   assign resp_dec       = imem_resp_valid ? CW'(1) : '0;

   assign instruction    = uop_valid_out ? buf_instr_reg[buf_rd_ptr_reg] : '0;
   assign pc_out         = uop_valid_out ? buf_pc_reg[buf_rd_ptr_reg] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_reg         <= RESET_PC;
         occ_reg        <= '0;
         out_reg        <= '0;
         drop_reg       <= '0;
         buf_wr_ptr_reg <= '0;
         buf_rd_ptr_reg <= '0;
         tag_wr_ptr_reg <= '0;
         tag_rd_ptr_reg <= '0;
      end else if (redirect_valid) begin
         // Everything still in flight after this edge belongs to the old path.
         pc_reg         <= redirect_target;
         occ_reg        <= '0;
         buf_wr_ptr_reg <= '0;
         buf_rd_ptr_reg <= '0;
         tag_wr_ptr_reg <= '0;
         tag_rd_ptr_reg <= '0;
         out_reg        <= out_reg - resp_dec;
         drop_reg       <= out_reg - resp_dec;
      end else begin
         if (accept) begin
            pc_reg         <= pc_reg + 32'd4;
            tag_wr_ptr_reg <= tag_wr_ptr_reg + PW'(1);
         end
         out_reg <= out_reg + CW'(accept) - resp_dec;
         if (drop_resp) begin
            drop_reg <= drop_reg - CW'(1);
         end
         if (push) begin
            buf_wr_ptr_reg <= buf_wr_ptr_reg + PW'(1);
            tag_rd_ptr_reg <= tag_rd_ptr_reg + PW'(1);
         end
         if (pop) begin
            buf_rd_ptr_reg <= buf_rd_ptr_reg + PW'(1);
         end
         occ_reg <= occ_reg + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         tag_pc_reg[tag_wr_ptr_reg] <= pc_reg;
      end
      if (push) begin
         buf_instr_reg[buf_wr_ptr_reg] <= imem_resp_data;
         buf_pc_reg[buf_wr_ptr_reg]    <= tag_pc_reg[tag_rd_ptr_reg];
      end
   end

endmodule
